// File: rtl/vram_arbiter.sv
// Pixel RAM arbiter: VGA scan-out reads first, then the framebuffer clear engine
// (present when VRAM_CLEAR_EN is defined), then two round-robin pixel writers.
module vram_arbiter #(
  parameter int FB_W        = 160,
  parameter int FB_H        = 120,
  parameter int SCALE_SHIFT = 2,
  parameter int ADDR_W      = 15,
  parameter int DATA_W      = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  p_tick,
  input  logic                  video_on,
  input  logic                  hsync,
  input  logic                  vsync,
  input  logic [9:0]            x,
  input  logic [9:0]            y,
  input  logic [1:0]            wr_req,
  input  logic [2*ADDR_W-1:0]   wr_addr,
  input  logic [2*DATA_W-1:0]   wr_data,
  output logic [1:0]            wr_ack,
  output logic                  wr_err,
  input  logic                  clr_req,
  input  logic [DATA_W-1:0]     clr_color,
  output logic                  clr_busy,
  output logic [ADDR_W-1:0]     mem_addr,
  output logic                  mem_we,
  output logic [DATA_W-1:0]     mem_wdata,
  input  logic [DATA_W-1:0]     mem_rdata,
  output logic                  hsync_o,
  output logic                  vsync_o,
  output logic                  video_on_o,
  output logic [7:0]            red,
  output logic [7:0]            green,
  output logic [7:0]            blue
);

  localparam int FB_SIZE = FB_W * FB_H;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FB_SIZE - 1);

  logic              scan;
  logic [ADDR_W-1:0] scan_addr;
  logic              last_grant;
  logic              gnt_idx;
  logic              grant_v;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_data;
  logic              sel_oor;
  logic [ADDR_W-1:0] clr_cnt;
  logic [DATA_W-1:0] clr_col;

  assign scan      = p_tick & video_on;
  assign scan_addr = ADDR_W'(((32'(y) >> SCALE_SHIFT) * 32'(FB_W)) + (32'(x) >> SCALE_SHIFT));

  // On a conflict the writer that did not win last time gets the slot.
  assign gnt_idx  = (&wr_req) ? ~last_grant : wr_req[1];
  assign grant_v  = ~scan & ~clr_busy & (|wr_req);
  assign sel_addr = gnt_idx ? wr_addr[2*ADDR_W-1:ADDR_W] : wr_addr[ADDR_W-1:0];
  assign sel_data = gnt_idx ? wr_data[2*DATA_W-1:DATA_W] : wr_data[DATA_W-1:0];
  assign sel_oor  = (32'(sel_addr) >= 32'(FB_SIZE));

`ifdef VRAM_CLEAR_EN
  // state   | meaning
  // S_IDLE  | no clear running, writers own the free cycles
  // S_CLEAR | one framebuffer address written per free cycle
  typedef enum logic {S_IDLE = 1'b0, S_CLEAR = 1'b1} clr_state_t;
  clr_state_t state, state_nxt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (clr_req) state_nxt = S_CLEAR;
      S_CLEAR: if (!scan && clr_cnt == LAST_ADDR) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    clr_busy = (state == S_CLEAR);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      clr_cnt <= '0;
      clr_col <= '0;
    end else if (state == S_IDLE && clr_req) begin
      clr_cnt <= '0;
      clr_col <= clr_color;
    end else if (state == S_CLEAR && !scan) begin
      clr_cnt <= clr_cnt + ADDR_W'(1);
    end
  end
`else
  logic unused_clr;
  assign unused_clr = ^{clr_req, clr_color};
  assign clr_busy   = 1'b0;
  assign clr_cnt    = '0;
  assign clr_col    = '0;
`endif

  always_comb begin
    mem_addr  = '0;
    mem_we    = 1'b0;
    mem_wdata = '0;
    wr_ack    = '0;
    wr_err    = 1'b0;
    if (scan) begin
      mem_addr = scan_addr;
    end else if (clr_busy) begin
      mem_addr  = clr_cnt;
      mem_we    = 1'b1;
      mem_wdata = clr_col;
    end else if (grant_v) begin
      mem_addr        = sel_addr;
      mem_wdata       = sel_data;
      mem_we          = ~sel_oor;
      wr_ack[gnt_idx] = 1'b1;
      wr_err          = sel_oor;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)        last_grant <= 1'b1;
    else if (grant_v) last_grant <= gnt_idx;
  end

  // Two-stage alignment: address cycle, RAM read cycle, then RGB register.
  logic scan_d1, vid_d1, hs_d1, vs_d1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      scan_d1    <= 1'b0;
      vid_d1     <= 1'b0;
      hs_d1      <= 1'b0;
      vs_d1      <= 1'b0;
      hsync_o    <= 1'b0;
      vsync_o    <= 1'b0;
      video_on_o <= 1'b0;
      red        <= '0;
      green      <= '0;
      blue       <= '0;
    end else begin
      scan_d1    <= scan;
      vid_d1     <= video_on;
      hs_d1      <= hsync;
      vs_d1      <= vsync;
      hsync_o    <= hs_d1;
      vsync_o    <= vs_d1;
      video_on_o <= vid_d1;
      if (!vid_d1) begin
        red   <= '0;
        green <= '0;
        blue  <= '0;
      end else if (scan_d1) begin
        red   <= {mem_rdata[7:5], mem_rdata[7:5], mem_rdata[7:6]};
        green <= {mem_rdata[4:2], mem_rdata[4:2], mem_rdata[4:3]};
        blue  <= {mem_rdata[1:0], mem_rdata[1:0], mem_rdata[1:0], mem_rdata[1:0]};
      end
    end
  end

endmodule

// File: tb/tb_vram_arbiter.sv
// Bench for vram_arbiter: directed scenarios plus a randomized run checked
// against a behavioural arbitration / pixel-pipeline model.
module tb_vram_arbiter;
  localparam int AW = 15;
  localparam int DW = 8;
  localparam int FB_SIZE = 19200;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          p_tick = 1'b0, video_on = 1'b0, hsync = 1'b0, vsync = 1'b0;
  logic [9:0]    x = '0, y = '0;
  logic [1:0]    wr_req = '0;
  logic [2*AW-1:0] wr_addr = '0;
  logic [2*DW-1:0] wr_data = '0;
  logic [1:0]    wr_ack;
  logic          wr_err;
  logic          clr_req = 1'b0;
  logic [DW-1:0] clr_color = '0;
  logic          clr_busy;
  logic [AW-1:0] mem_addr;
  logic          mem_we;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata = '0;
  logic          hsync_o, vsync_o, video_on_o;
  logic [7:0]    red, green, blue;

  int errors = 0;
  int checks = 0;

  logic [7:0] ram [0:32767];
  logic [7:0] ref_mem [0:FB_SIZE-1];
  logic       ram_fill = 1'b0;

  vram_arbiter dut (
    .clk(clk), .reset(reset), .p_tick(p_tick), .video_on(video_on),
    .hsync(hsync), .vsync(vsync), .x(x), .y(y),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_ack(wr_ack), .wr_err(wr_err),
    .clr_req(clr_req), .clr_color(clr_color), .clr_busy(clr_busy),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .hsync_o(hsync_o), .vsync_o(vsync_o), .video_on_o(video_on_o),
    .red(red), .green(green), .blue(blue)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] pat(input int i);
    return 8'((i * 37 + 11) & 255);
  endfunction

  // RGB332 to 888 as round(v*255/max), independent of bit layout tricks.
  function automatic logic [23:0] expand(input logic [7:0] d);
    int r, g, b;
    r = int'(d[7:5]);
    g = int'(d[4:2]);
    b = int'(d[1:0]);
    return {8'((r * 255 + 3) / 7), 8'((g * 255 + 3) / 7), 8'(b * 85)};
  endfunction

  always @(posedge clk) begin
    if (ram_fill) begin
      for (int i = 0; i < 32768; i++) ram[i] <= pat(i);
    end else begin
      if (mem_we) ram[mem_addr] <= mem_wdata;
      mem_rdata <= ram[mem_addr];
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    p_tick = 0; video_on = 0; hsync = 0; vsync = 0; x = '0; y = '0;
    wr_req = '0; wr_addr = '0; wr_data = '0; clr_req = 0; clr_color = '0;
  endtask

  task automatic do_reset();
    reset = 1;
    clear_inputs();
    repeat (2) @(posedge clk);
    #1;
    reset = 0;
  endtask

  task automatic test_reset();
    reset = 1;
    clear_inputs();
    @(negedge clk);
    checks++;
    if ({mem_we, wr_ack, wr_err, clr_busy, hsync_o, vsync_o, video_on_o} !== 8'h00) begin
      errors++;
      $display("FAIL reset_ctrl: got %b expected 00000000",
               {mem_we, wr_ack, wr_err, clr_busy, hsync_o, vsync_o, video_on_o});
    end
    checks++;
    if ({red, green, blue} !== 24'h0) begin
      errors++;
      $display("FAIL reset_rgb: got %h expected 000000", {red, green, blue});
    end
    tick();
    reset = 0;
  endtask

  task automatic test_single_write();
    do_reset();
    wr_req = 2'b01; wr_addr = {15'd0, 15'd5}; wr_data = {8'h00, 8'hE0};
    @(negedge clk);
    checks++;
    if ({mem_we, wr_ack, wr_err, mem_addr, mem_wdata} !== {1'b1, 2'b01, 1'b0, 15'd5, 8'hE0}) begin
      errors++;
      $display("FAIL single_write: got we=%b ack=%b err=%b addr=%0d data=%h expected we=1 ack=01 err=0 addr=5 data=e0",
               mem_we, wr_ack, wr_err, mem_addr, mem_wdata);
    end
    tick();
    wr_req = '0; p_tick = 1; video_on = 1; x = 10'd20; y = 10'd0;
    @(negedge clk);
    checks++;
    if ({mem_we, mem_addr} !== {1'b0, 15'd5}) begin
      errors++;
      $display("FAIL scan_addr: got we=%b addr=%0d expected we=0 addr=5", mem_we, mem_addr);
    end
    tick();
    p_tick = 0;
    tick();
    p_tick = 1; x = 10'd24;
    @(negedge clk);
    checks++;
    if ({red, green, blue, video_on_o} !== {24'hFF0000, 1'b1}) begin
      errors++;
      $display("FAIL scan_pixel: got rgb=%h von=%b expected rgb=ff0000 von=1",
               {red, green, blue}, video_on_o);
    end
    tick();
    clear_inputs();
  endtask

  task automatic test_round_robin();
    logic [1:0] exp;
    do_reset();
    wr_req = 2'b11; wr_addr = {15'd200, 15'd100}; wr_data = {8'h22, 8'h11};
    for (int i = 0; i < 8; i++) begin
      exp = (i % 2 == 0) ? 2'b01 : 2'b10;
      @(negedge clk);
      checks++;
      if (wr_ack !== exp) begin
        errors++;
        $display("FAIL round_robin[%0d]: got %b expected %b", i, wr_ack, exp);
      end
      tick();
    end
    wr_req = '0;
  endtask

  task automatic test_active_video();
    logic got;
    got = 0;
    video_on = 1; p_tick = 1; x = 10'd100; y = 10'd40;
    wr_req = 2'b10; wr_addr = {15'd300, 15'd0}; wr_data = {8'h33, 8'h00};
    for (int i = 0; i < 8 && !got; i++) begin
      @(negedge clk);
      checks++;
      if ((mem_we & p_tick) !== 1'b0) begin
        errors++;
        $display("FAIL active_we_on_tick: got we=%b on p_tick=1 expected 0", mem_we);
      end
      if (wr_ack !== 2'b00) begin
        got = 1;
        checks++;
        if ({p_tick, wr_ack} !== {1'b0, 2'b10}) begin
          errors++;
          $display("FAIL active_ack: got p_tick=%b ack=%b expected p_tick=0 ack=10", p_tick, wr_ack);
        end
      end
      tick();
      p_tick = ~p_tick;
    end
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL active_timeout: got no ack expected ack within 8 clk");
    end
    clear_inputs();
  endtask

  task automatic test_out_of_range();
    wr_req = 2'b01; wr_addr = {15'd0, 15'd19200}; wr_data = {8'h00, 8'h77};
    @(negedge clk);
    checks++;
    if ({mem_we, wr_ack, wr_err} !== {1'b0, 2'b01, 1'b1}) begin
      errors++;
      $display("FAIL oor_19200: got we=%b ack=%b err=%b expected we=0 ack=01 err=1", mem_we, wr_ack, wr_err);
    end
    tick();
    wr_addr = {15'd0, 15'd19199};
    @(negedge clk);
    checks++;
    if ({mem_we, wr_ack, wr_err, mem_addr} !== {1'b1, 2'b01, 1'b0, 15'd19199}) begin
      errors++;
      $display("FAIL oor_19199: got we=%b ack=%b err=%b addr=%0d expected we=1 ack=01 err=0 addr=19199",
               mem_we, wr_ack, wr_err, mem_addr);
    end
    tick();
    wr_req = '0;
  endtask

`ifdef VRAM_CLEAR_EN
  task automatic test_clear();
    int busy_cnt, acks_during, seq_err, bad_cells;
    logic fell;
    busy_cnt = 0; acks_during = 0; seq_err = 0; bad_cells = 0; fell = 0;
    do_reset();
    clr_req = 1; clr_color = 8'h1C;
    @(negedge clk);
    checks++;
    if (clr_busy !== 1'b0) begin
      errors++;
      $display("FAIL clear_start_busy: got %b expected 0", clr_busy);
    end
    tick();
    clr_req = 0;
    wr_req = 2'b01; wr_addr = {15'd0, 15'd7}; wr_data = {8'h00, 8'hAA};
    for (int i = 0; i < 20000; i++) begin
      @(negedge clk);
      if (!clr_busy) begin
        fell = 1;
        break;
      end
      busy_cnt++;
      if (wr_ack !== 2'b00) acks_during++;
      if ({mem_we, mem_addr, mem_wdata} !== {1'b1, 15'(busy_cnt - 1), 8'h1C}) seq_err++;
      tick();
      clr_req = (busy_cnt == 100);
      clr_color = (busy_cnt == 100) ? 8'hFF : 8'h1C;
    end
    checks++;
    if (!fell || busy_cnt != FB_SIZE) begin
      errors++;
      $display("FAIL clear_duration: got %0d busy clk expected %0d", busy_cnt, FB_SIZE);
    end
    checks++;
    if (acks_during != 0 || seq_err != 0) begin
      errors++;
      $display("FAIL clear_sequence: got %0d acks and %0d bad writes expected 0 and 0", acks_during, seq_err);
    end
    checks++;
    if (wr_ack !== 2'b01) begin
      errors++;
      $display("FAIL clear_release_ack: got %b expected 01", wr_ack);
    end
    tick();
    wr_req = '0;
    for (int i = 0; i < FB_SIZE; i++)
      if (i != 7 && ram[i] !== 8'h1C) bad_cells++;
    checks++;
    if (bad_cells != 0 || ram[7] !== 8'hAA) begin
      errors++;
      $display("FAIL clear_contents: got %0d bad cells, cell7=%h expected 0, aa", bad_cells, ram[7]);
    end

    clr_req = 1; clr_color = 8'hE3;
    tick();
    clr_req = 0;
    repeat (50) tick();
    reset = 1;
    #1;
    checks++;
    if ({clr_busy, red, green, blue} !== 25'h0) begin
      errors++;
      $display("FAIL reset_mid_clear: got busy=%b rgb=%h expected busy=0 rgb=000000", clr_busy, {red, green, blue});
    end
    @(posedge clk);
    #1;
    reset = 0;
    clr_req = 1;
    tick();
    clr_req = 0;
    @(negedge clk);
    checks++;
    if ({clr_busy, mem_we, mem_addr} !== {1'b1, 1'b1, 15'd0}) begin
      errors++;
      $display("FAIL clear_restart: got busy=%b we=%b addr=%0d expected busy=1 we=1 addr=0", clr_busy, mem_we, mem_addr);
    end
    do_reset();
  endtask
`else
  task automatic test_clear_disabled();
    clr_req = 1; clr_color = 8'h55;
    wr_req = 2'b01; wr_addr = {15'd0, 15'd9}; wr_data = {8'h00, 8'h99};
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if ({clr_busy, mem_we, wr_ack, mem_wdata} !== {1'b0, 1'b1, 2'b01, 8'h99}) begin
        errors++;
        $display("FAIL clear_disabled[%0d]: got busy=%b we=%b ack=%b data=%h expected busy=0 we=1 ack=01 data=99",
                 i, clr_busy, mem_we, wr_ack, mem_wdata);
      end
      tick();
    end
    clear_inputs();
  endtask
`endif

  task automatic test_random();
    int m_last, w, ea, a[2];
    logic pend[2];
    logic [7:0] d[2];
    logic sc, e_we, e_err, oor;
    logic [1:0] e_ack;
    logic [7:0] e_wd;
    logic d1_vid, d1_hs, d1_vs, d1_sc, d2_vid, d2_hs, d2_vs, d2_sc;
    logic [7:0] d1_pix, d2_pix;
    logic [23:0] prev_rgb, e_rgb;
    ram_fill = 1;
    do_reset();
    ram_fill = 0;
    for (int i = 0; i < FB_SIZE; i++) ref_mem[i] = pat(i);
    m_last = 1;
    pend[0] = 0; pend[1] = 0; a[0] = 0; a[1] = 0; d[0] = 0; d[1] = 0;
    {d1_vid, d1_hs, d1_vs, d1_sc, d2_vid, d2_hs, d2_vs, d2_sc} = '0;
    d1_pix = 0; d2_pix = 0; prev_rgb = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      p_tick = ~p_tick;
      if (cyc % 24 == 0) video_on = ($urandom_range(0, 2) != 0);
      hsync = 1'($urandom); vsync = 1'($urandom);
      x = 10'($urandom_range(0, 639)); y = 10'($urandom_range(0, 479));
      for (int k = 0; k < 2; k++) begin
        if (!pend[k] && $urandom_range(0, 1) == 1) begin
          pend[k] = 1;
          a[k] = ($urandom_range(0, 15) == 0) ? 19200 + int'($urandom_range(0, 100))
                                              : int'($urandom_range(0, FB_SIZE - 1));
          d[k] = 8'($urandom);
        end
      end
      wr_req = {pend[1], pend[0]};
      wr_addr = {15'(a[1]), 15'(a[0])};
      wr_data = {d[1], d[0]};

      sc = p_tick && video_on;
      e_we = 0; e_err = 0; e_ack = 0; e_wd = 0; ea = 0; w = 0;
      if (sc) begin
        ea = (int'(y) / 4) * 160 + int'(x) / 4;
      end else if (pend[0] || pend[1]) begin
        if (pend[0] && pend[1]) w = (m_last == 0) ? 1 : 0;
        else w = pend[1] ? 1 : 0;
        oor = (a[w] >= FB_SIZE);
        e_ack = (w == 1) ? 2'b10 : 2'b01;
        e_err = oor; e_we = !oor; ea = a[w]; e_wd = d[w];
        m_last = w;
      end

      if (!d2_vid) e_rgb = 0;
      else if (d2_sc) e_rgb = expand(d2_pix);
      else e_rgb = prev_rgb;
      prev_rgb = e_rgb;

      @(negedge clk);
      checks++;
      if ({mem_we, wr_ack, wr_err} !== {e_we, e_ack, e_err}) begin
        errors++;
        $display("FAIL rand_ctrl@%0d: got we=%b ack=%b err=%b expected we=%b ack=%b err=%b",
                 cyc, mem_we, wr_ack, wr_err, e_we, e_ack, e_err);
      end
      if (sc || e_we) begin
        checks++;
        if (mem_addr !== 15'(ea) || (e_we && mem_wdata !== e_wd)) begin
          errors++;
          $display("FAIL rand_addr@%0d: got addr=%0d data=%h expected addr=%0d data=%h",
                   cyc, mem_addr, mem_wdata, ea, e_wd);
        end
      end
      checks++;
      if ({hsync_o, vsync_o, video_on_o} !== {d2_hs, d2_vs, d2_vid}) begin
        errors++;
        $display("FAIL rand_sync@%0d: got %b expected %b", cyc,
                 {hsync_o, vsync_o, video_on_o}, {d2_hs, d2_vs, d2_vid});
      end
      checks++;
      if ({red, green, blue} !== e_rgb) begin
        errors++;
        $display("FAIL rand_rgb@%0d: got %h expected %h", cyc, {red, green, blue}, e_rgb);
      end

      if (e_ack != 0) pend[w] = 0;
      if (e_we) ref_mem[ea] = e_wd;
      {d2_vid, d2_hs, d2_vs, d2_sc, d2_pix} = {d1_vid, d1_hs, d1_vs, d1_sc, d1_pix};
      {d1_vid, d1_hs, d1_vs, d1_sc} = {video_on, hsync, vsync, sc};
      d1_pix = sc ? ref_mem[ea] : 8'h00;
      tick();
    end
    clear_inputs();
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_round_robin();
    test_active_video();
    test_out_of_range();
`ifdef VRAM_CLEAR_EN
    test_clear();
`else
    test_clear_disabled();
`endif
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
